// File: rtl/relu1_seq_pkg.sv
// relu1_seq_pkg: shared types and default constants for the ReLU1 sequencer.
//   state_t          - sequencer FSM state (IDLE, RUN, FLUSH, DONE)
//   *_DEF            - default widths / element count
//   LEAKY_SHIFT      - right-shift applied to negative inputs in the leaky build
package relu1_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int NUM_ELEMS_DEF  = 64;
  localparam int CNT_WIDTH_DEF  = 7;
  localparam int LEAKY_SHIFT    = 3;

endpackage

// File: rtl/relu1_sequencer_if.sv
// relu1_mem_if: memory-side bus of the ReLU1 sequencer.
//   src_read_addr    - read address into the source (fc1 output) memory
//   src_data         - combinational read data for src_read_addr
//   dst_write_addr   - write address into the ReLU1 memory
//   dst_data_out     - activated value to write
//   dst_write_enable - write strobe, captured on the rising edge
// Modports: master = sequencer, slave = memory side.
interface relu1_mem_if
  import relu1_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic        [ADDR_WIDTH-1:0] src_read_addr;
  logic signed [DATA_WIDTH-1:0] src_data;
  logic        [ADDR_WIDTH-1:0] dst_write_addr;
  logic signed [DATA_WIDTH-1:0] dst_data_out;
  logic                         dst_write_enable;

  modport master (
    output src_read_addr, dst_write_addr, dst_data_out, dst_write_enable,
    input  src_data
  );

  modport slave (
    input  src_read_addr, dst_write_addr, dst_data_out, dst_write_enable,
    output src_data
  );
endinterface

// File: rtl/relu1_sequencer_act.sv
// relu1_act: combinational activation function.
//   i_x - signed pre-activation value
//   o_y - activated value
// Macro RELU1_LEAKY_EN: when defined, negative inputs become x >>> LEAKY_SHIFT
// (floor division by 8); otherwise negative inputs become 0.
module relu1_act
  import relu1_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] i_x,
  output logic signed [DATA_WIDTH-1:0] o_y
);

  logic w_neg;
  assign w_neg = i_x[DATA_WIDTH-1];

`ifdef RELU1_LEAKY_EN
  // Arithmetic shift keeps the sign, so the result rounds toward -inf.
  assign o_y = w_neg ? (i_x >>> LEAKY_SHIFT) : i_x;
`else
  assign o_y = w_neg ? '0 : i_x;
`endif

endmodule

// File: rtl/relu1_sequencer.sv
// relu1_sequencer: walks the source memory 0..NUM_ELEMS-1, applies the
// activation and writes each result to the ReLU1 memory one cycle later.
//   clk, reset        - clock, synchronous active-high reset
//   start             - begin a run (honoured only in IDLE)
//   busy              - state != IDLE
//   done              - one-cycle pulse after the last write
//   nonzero_count     - nonzero values written in the last/current run
//   mem (master)      - source read / destination write bus
// Macro RELU1_LEAKY_EN selects the leaky activation inside relu1_act.
module relu1_sequencer
  import relu1_seq_pkg::*;
#(
  parameter int NUM_ELEMS  = NUM_ELEMS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] nonzero_count,
  relu1_mem_if.master          mem
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ELEMS - 1);

  state_t                       r_state, w_next;
  logic        [ADDR_WIDTH-1:0] r_rd_cnt;
  logic                         r_pipe_valid;
  logic        [ADDR_WIDTH-1:0] r_pipe_addr;
  logic signed [DATA_WIDTH-1:0] r_pipe_data;
  logic        [CNT_WIDTH-1:0]  r_nz_cnt;
  logic signed [DATA_WIDTH-1:0] w_act;
  logic        [ADDR_WIDTH-1:0] w_src_addr;
  logic                         w_last;

  assign w_last = (r_rd_cnt == LAST_ADDR);

  relu1_act #(.DATA_WIDTH(DATA_WIDTH)) u_act (
    .i_x (mem.src_data),
    .o_y (w_act)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    busy       = (r_state != ST_IDLE);
    done       = 1'b0;
    w_src_addr = '0;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_RUN;
      ST_RUN: begin
        w_src_addr = r_rd_cnt;
        if (w_last) w_next = ST_FLUSH;
      end
      ST_FLUSH: w_next = ST_DONE;
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // Counter, single pipeline stage and nonzero tally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_cnt     <= '0;
      r_pipe_valid <= 1'b0;
      r_pipe_addr  <= '0;
      r_pipe_data  <= '0;
      r_nz_cnt     <= '0;
    end else begin
      // Count on the edge the write actually lands.
      if (r_pipe_valid && (r_pipe_data != '0)) r_nz_cnt <= r_nz_cnt + CNT_WIDTH'(1);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rd_cnt <= '0;
            r_nz_cnt <= '0;
          end
        end
        ST_RUN: begin
          r_pipe_data  <= w_act;
          r_pipe_addr  <= r_rd_cnt;
          r_pipe_valid <= 1'b1;
          if (!w_last) r_rd_cnt <= r_rd_cnt + ADDR_WIDTH'(1);
        end
        ST_FLUSH: r_pipe_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem.src_read_addr    = w_src_addr;
  assign mem.dst_write_enable = r_pipe_valid;
  assign mem.dst_write_addr   = r_pipe_addr;
  assign mem.dst_data_out     = r_pipe_data;
  assign nonzero_count        = r_nz_cnt;

endmodule

// File: tb/tb_relu1_sequencer.sv
module tb_relu1_sequencer;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done;
  logic [6:0] nz;

  relu1_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) mif ();

  relu1_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .nonzero_count (nz),
    .mem           (mif)
  );

  always #5 clk = ~clk;

  // Source memory with combinational read.
  logic signed [31:0] src [N];
  assign mif.src_data = (mif.src_read_addr < 16'(N)) ? src[mif.src_read_addr[5:0]] : 32'sd0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          edge_n;
  } wr_t;

  wr_t wq[$];
  int  done_cyc[$];
  int  busy_cycles;
  int  n_chk  = 0;
  int  n_pass = 0;

  // Monitor away from the active edge; a write seen now lands on the next edge.
  always @(negedge clk) begin
    if (mif.dst_write_enable) wq.push_back('{int'(mif.dst_write_addr), mif.dst_data_out, cyc + 1});
    if (done) done_cyc.push_back(cyc);
    if (busy) busy_cycles++;
  end

  // Reference activation: plain arithmetic on the signed value.
  function automatic logic [31:0] act_ref(input logic signed [31:0] x);
    longint v;
    v = x;
    if (v >= 0) return x;
`ifdef RELU1_LEAKY_EN
    return 32'(-((-v + 7) / 8));
`else
    return 32'd0;
`endif
  endfunction

  function automatic int nz_ref();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (act_ref(src[i]) != 0) c++;
    return c;
  endfunction

  task automatic clear_mon();
    wq.delete();
    done_cyc.delete();
    busy_cycles = 0;
  endtask

  // Accept a start, keep it high for 'hold' extra edges, wait for done.
  task automatic do_run(input int hold, output int s_edge);
    clear_mon();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 s_edge = cyc;
    repeat (hold) @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 200 && done_cyc.size() == 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
    n_chk++; if (mif.dst_write_enable !== 1'b0) $display("FAIL rst_we got %b exp 0", mif.dst_write_enable); else n_pass++;
    n_chk++; if (mif.src_read_addr !== 16'd0) $display("FAIL rst_raddr got %0d exp 0", mif.src_read_addr); else n_pass++;
    n_chk++; if (nz !== 7'd0) $display("FAIL rst_nz got %0d exp 0", nz); else n_pass++;
    @(negedge clk) reset = 1'b0;
  endtask

  // Ramp, most-negative, and random patterns through full runs.
  task automatic test_patterns();
    int s;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < N; i++) begin
        case (p)
          0:       src[i] = i - 32;
          1:       src[i] = 32'sh8000_0000;
          default: src[i] = ($urandom_range(0, 7) == 0) ? 32'sd0 : $signed($urandom);
        endcase
      end
      do_run(0, s);
      n_chk++; if (wq.size() !== N) $display("FAIL pat%0d_wr_count got %0d exp %0d", p, wq.size(), N); else n_pass++;
      for (int i = 0; i < N && i < wq.size(); i++) begin
        n_chk++;
        if (wq[i].addr !== i || wq[i].data !== act_ref(src[i]) || wq[i].edge_n !== s + 2 + i)
          $display("FAIL pat%0d_wr%0d got a=%0d d=%h e=%0d exp a=%0d d=%h e=%0d", p, i,
                   wq[i].addr, wq[i].data, wq[i].edge_n, i, act_ref(src[i]), s + 2 + i);
        else n_pass++;
      end
      n_chk++; if (done_cyc.size() !== 1 || done_cyc[0] !== s + N + 1)
        $display("FAIL pat%0d_done got n=%0d c=%0d exp n=1 c=%0d", p, done_cyc.size(),
                 (done_cyc.size() > 0) ? done_cyc[0] - s : -1, N + 1);
      else n_pass++;
      n_chk++; if (int'(nz) !== nz_ref()) $display("FAIL pat%0d_nz got %0d exp %0d", p, nz, nz_ref()); else n_pass++;
      n_chk++; if (busy_cycles !== N + 2) $display("FAIL pat%0d_busy got %0d exp %0d", p, busy_cycles, N + 2); else n_pass++;
`ifndef RELU1_LEAKY_EN
      if (p == 0) begin
        n_chk++; if (nz !== 7'd31) $display("FAIL ramp_nz got %0d exp 31", nz); else n_pass++;
      end
`endif
    end
  endtask

  task automatic test_start_hold();
    int s;
    for (int i = 0; i < N; i++) src[i] = $signed($urandom);
    do_run(40, s);
    repeat (5) @(negedge clk);
    n_chk++; if (wq.size() !== N) $display("FAIL hold_wr_count got %0d exp %0d", wq.size(), N); else n_pass++;
    n_chk++; if (done_cyc.size() !== 1) $display("FAIL hold_done_count got %0d exp 1", done_cyc.size()); else n_pass++;
    n_chk++; if (busy_cycles !== N + 2) $display("FAIL hold_busy got %0d exp %0d", busy_cycles, N + 2); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s, ok, bad;
    for (int i = 0; i < N; i++) src[i] = i - 32;
    clear_mon();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 200 && !done; k++) @(negedge clk);
    n_chk++; if (done !== 1'b1) $display("FAIL b2b_first_done got %b exp 1", done); else n_pass++;
    for (int i = 0; i < N; i++) src[i] = $signed($urandom);
    @(negedge clk) start = 1'b1;
    clear_mon();
    @(posedge clk);
    #1 s = cyc;
    n_chk++; if (nz !== 7'd0) $display("FAIL b2b_nz_clear got %0d exp 0", nz); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b exp 1", busy); else n_pass++;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 200 && done_cyc.size() == 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    bad = 0;
    ok  = (wq.size() == N);
    for (int i = 0; i < N && i < wq.size(); i++)
      if (wq[i].addr !== i || wq[i].data !== act_ref(src[i]) || wq[i].edge_n !== s + 2 + i) bad++;
    n_chk++; if (!ok || bad != 0) $display("FAIL b2b_second_run got writes=%0d bad=%0d exp writes=%0d bad=0", wq.size(), bad, N); else n_pass++;
    n_chk++; if (int'(nz) !== nz_ref()) $display("FAIL b2b_nz got %0d exp %0d", nz, nz_ref()); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int s, bad;
    for (int i = 0; i < N; i++) src[i] = i - 32;
    clear_mon();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk) start = 1'b0;
    while (cyc < s + 19) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else n_pass++;
    n_chk++; if (mif.dst_write_enable !== 1'b0) $display("FAIL midrst_we got %b exp 0", mif.dst_write_enable); else n_pass++;
    @(negedge clk) reset = 1'b0;
    repeat (80) @(negedge clk);
    n_chk++; if (done_cyc.size() !== 0) $display("FAIL midrst_done got %0d pulses exp 0", done_cyc.size()); else n_pass++;
    do_run(0, s);
    bad = 0;
    for (int i = 0; i < N && i < wq.size(); i++)
      if (wq[i].addr !== i || wq[i].data !== act_ref(src[i]) || wq[i].edge_n !== s + 2 + i) bad++;
    n_chk++; if (wq.size() !== N || bad != 0) $display("FAIL midrst_rerun got writes=%0d bad=%0d exp writes=%0d bad=0", wq.size(), bad, N); else n_pass++;
    n_chk++; if (done_cyc.size() !== 1) $display("FAIL midrst_rerun_done got %0d exp 1", done_cyc.size()); else n_pass++;
  endtask

`ifdef RELU1_LEAKY_EN
  task automatic test_leaky();
    int s;
    logic [31:0] exp4 [4];
    exp4[0] = 32'hFFFF_FFFF; exp4[1] = 32'hFFFF_FFFF; exp4[2] = 32'hFFFF_FFFE; exp4[3] = 32'd7;
    for (int i = 0; i < N; i++) src[i] = 32'sd0;
    src[0] = -1; src[1] = -8; src[2] = -16; src[3] = 7;
    do_run(0, s);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (wq.size() <= i || wq[i].data !== exp4[i])
        $display("FAIL leaky%0d got %h exp %h", i, (wq.size() > i) ? wq[i].data : 32'hx, exp4[i]);
      else n_pass++;
    end
    n_chk++; if (nz !== 7'd4) $display("FAIL leaky_nz got %0d exp 4", nz); else n_pass++;
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_patterns();
    test_start_hold();
    test_back_to_back();
    test_reset_midrun();
`ifdef RELU1_LEAKY_EN
    test_leaky();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
